imem_loader: RTL and testbench

Program loader that encodes a stream of instruction descriptors into 16-bit machine words and writes them sequentially into instruction memory. It is the writer side of the instruction path: it produces the words whose opcode and function fields the control unit later decodes. It sits between the testbench/host stimulus port and the instruction-memory write port, and runs before the core is released from reset.

---
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: encodes a stream of instruction descriptors into 16-bit
// machine words and writes them sequentially into instruction memory,
// starting at address 0 each session. Illegal descriptors are counted and
// dropped without consuming an address.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [1:0]        op_reg,
    input  logic [7:0]        op_func,
    input  logic [11:0]       op_data,
    input  logic              op_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [1:0] state;
    logic       last_q;
    logic       desc_legal;
    logic [15:0] desc_word;

    // True when the opcode is known and, for TYPEC, the function is one-hot legal.
    function automatic logic is_legal(input logic [3:0] code, input logic [7:0] func);
        logic ok;
        ok = 1'b0;
        case (code)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: ok = 1'b1;
            4'b1000: begin
                case (func)
                    8'b0000_0010, 8'b0000_0100, 8'b0000_1000,
                    8'b0001_0000, 8'b0100_0000: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Packs a descriptor into its machine word; opcode always occupies the top nibble.
    function automatic logic [15:0] encode(input logic [3:0] code, input logic [1:0] rg,
                                           input logic [7:0] func, input logic [11:0] data);
        logic [15:0] w;
        case (code)
            4'b1000:                             w = {code, rg, 2'b00, func};
            4'b1100, 4'b1101, 4'b1110, 4'b1111: w = {code, rg, data[9:0]};
            default:                             w = {code, data};
        endcase
        return w;
    endfunction

    assign desc_legal = is_legal(op_code, op_func);
    assign desc_word  = encode(op_code, op_reg, op_func, op_data);

    // Status outputs decode the state register directly, so an asynchronous
    // reset drops mem_we in the same instant it clears the state.
    assign op_ready = (state == S_ACCEPT);
    assign mem_we   = (state == S_WRITE);
    assign busy     = (state == S_ACCEPT) || (state == S_WRITE);
    assign done     = (state == S_DONE);

    // Session FSM: accept one descriptor, write it for one cycle, advance address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last_q    <= 1'b0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_ACCEPT;
                        mem_addr <= '0;
                        full     <= 1'b0;
                        err      <= 1'b0;
                        err_cnt  <= '0;
                    end
                end
                S_ACCEPT: begin
                    if (op_valid) begin
                        if (desc_legal) begin
                            mem_wdata <= desc_word;
                            last_q    <= op_last;
                            state     <= S_WRITE;
                        end else begin
                            // Rejected descriptors consume no address but still can end the session.
                            err <= 1'b1;
                            if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 8'd1;
                            end
                            if (op_last) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (last_q) begin
                        state <= S_DONE;
                    end else if (mem_addr == ADDR_MAX) begin
                        // Never wrap: the session stops with the address on the last slot.
                        full  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        state    <= S_ACCEPT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed descriptors with hand-encoded words
// pushed into a scoreboard queue; a negedge monitor pops and compares every
// memory write. Status outputs are checked inline at chosen cycles.
module tb_imem_loader;

    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [1:0]    op_reg;
    logic [7:0]    op_func;
    logic [11:0]   op_data;
    logic          op_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          full;
    logic          err;
    logic [7:0]    err_cnt;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [15:0]   exp_data_q[$];

    imem_loader #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_reg   (op_reg),
        .op_func  (op_func),
        .op_data  (op_data),
        .op_last  (op_last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .full     (full),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [15:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            vec_cnt++;
            if (exp_addr_q.size() == 0) begin
                miss_cnt++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
            end else begin
                logic [AW-1:0] ea;
                logic [15:0]   ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (mem_addr !== ea || mem_wdata !== ed) begin
                    miss_cnt++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             mem_addr, mem_wdata, ea, ed);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the session in ACCEPT.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ready", 16'(op_ready), 16'd1);
        chk("start_done_clr", 16'(done), 16'd0);
    endtask

    // Presents one descriptor until accepted; returns at posedge+1 after the handshake.
    task automatic send(input logic [3:0] c, input logic [1:0] r, input logic [7:0] f,
                        input logic [11:0] d, input logic l);
        int n;
        op_valid = 1'b1;
        op_code  = c;
        op_reg   = r;
        op_func  = f;
        op_data  = d;
        op_last  = l;
        n = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL send_timeout: got op_ready %b after %0d cycles, expected 1", op_ready, n);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_op_ready"}, 16'(op_ready), 16'd0);
        chk({tag, "_mem_we"},   16'(mem_we),   16'd0);
        chk({tag, "_mem_addr"}, 16'(mem_addr), 16'd0);
        chk({tag, "_wdata"},    mem_wdata,     16'h0000);
        chk({tag, "_busy"},     16'(busy),     16'd0);
        chk({tag, "_done"},     16'(done),     16'd0);
        chk({tag, "_full"},     16'(full),     16'd0);
        chk({tag, "_err"},      16'(err),      16'd0);
        chk({tag, "_err_cnt"},  16'(err_cnt),  16'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_valid = 1'b0; op_code = 4'h0; op_reg = 2'b00;
        op_func = 8'h00; op_data = 12'h000; op_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 16'(op_ready), 16'd0);

        // Basic two-word program: ADDI then LOAD.
        do_start();
        expect_write(2'd0, 16'hC805);
        send(4'b1100, 2'd2, 8'h00, 12'h005, 1'b0);
        chk("write_busy", 16'(busy), 16'd1);
        expect_write(2'd1, 16'h00A3);
        send(4'b0000, 2'd0, 8'h00, 12'h0A3, 1'b1);
        @(posedge clk); #1;
        chk("t1_done", 16'(done), 16'd1);
        chk("t1_busy", 16'(busy), 16'd0);
        chk("t1_err", 16'(err), 16'd0);
        chk("t1_addr_hold", 16'(mem_addr), 16'd1);

        // TYPEC legal, TYPEC illegal function, then ORI at the same address.
        do_start();
        expect_write(2'd0, 16'h8404);
        send(4'b1000, 2'd1, 8'b0000_0100, 12'h000, 1'b0);
        @(posedge clk); #1;
        send(4'b1000, 2'd1, 8'b0000_0110, 12'h000, 1'b0);
        chk("t2_err", 16'(err), 16'd1);
        chk("t2_err_cnt", 16'(err_cnt), 16'd1);
        chk("t2_ready_after_rej", 16'(op_ready), 16'd1);
        chk("t2_no_write", 16'(mem_we), 16'd0);
        expect_write(2'd1, 16'hFC2A);
        send(4'b1111, 2'd3, 8'h00, 12'hC2A, 1'b1);
        @(posedge clk); #1;
        chk("t2_done", 16'(done), 16'd1);
        chk("t2_err_sticky", 16'(err), 16'd1);

        // Illegal opcode marked last ends the session without a write.
        do_start();
        chk("t3_err_clr", 16'(err), 16'd0);
        chk("t3_cnt_clr", 16'(err_cnt), 16'd0);
        send(4'b0011, 2'd0, 8'h00, 12'h123, 1'b1);
        chk("t3_done", 16'(done), 16'd1);
        chk("t3_busy", 16'(busy), 16'd0);
        chk("t3_err_cnt", 16'(err_cnt), 16'd1);
        chk("t3_addr", 16'(mem_addr), 16'd0);
        chk("t3_full", 16'(full), 16'd0);

        // Fill all four locations; the session ends full without wrapping.
        do_start();
        expect_write(2'd0, 16'h8040);
        send(4'b1000, 2'd0, 8'b0100_0000, 12'h000, 1'b0);
        expect_write(2'd1, 16'hD7FF);
        send(4'b1101, 2'd1, 8'h00, 12'h3FF, 1'b0);
        expect_write(2'd2, 16'hE000);
        send(4'b1110, 2'd0, 8'h00, 12'hC00, 1'b0);
        expect_write(2'd3, 16'h40FF);
        send(4'b0100, 2'd0, 8'h00, 12'h0FF, 1'b0);
        @(posedge clk); #1;
        chk("t4_done", 16'(done), 16'd1);
        chk("t4_full", 16'(full), 16'd1);
        chk("t4_ready", 16'(op_ready), 16'd0);
        chk("t4_addr", 16'(mem_addr), 16'd3);
        op_valid = 1'b1; op_code = 4'b0010; op_data = 12'h055;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t4_no_accept", 16'(op_ready), 16'd0);
        end
        op_valid = 1'b0;

        // Reset asserted during the WRITE cycle drops the write at once.
        do_start();
        chk("t5_full_clr", 16'(full), 16'd0);
        send(4'b0010, 2'd0, 8'h00, 12'h777, 1'b0);
        chk("t5_in_write", 16'(mem_we), 16'd1);
        #1 rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        do_start();
        expect_write(2'd0, 16'hC001);
        send(4'b1100, 2'd0, 8'h00, 12'h001, 1'b1);
        @(posedge clk); #1;
        chk("t5_done", 16'(done), 16'd1);

        // Back-to-back STOREs with op_valid held; start pulses are ignored.
        do_start();
        expect_write(2'd0, 16'h1011);
        expect_write(2'd1, 16'h1022);
        expect_write(2'd2, 16'h1033);
        op_valid = 1'b1; op_code = 4'b0001; op_reg = 2'd0; op_data = 12'h011; op_last = 1'b0;
        @(posedge clk); #1;
        chk("t6_we1", 16'(mem_we), 16'd1);
        chk("t6_ready1", 16'(op_ready), 16'd0);
        op_data = 12'h022;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t6_gap_we", 16'(mem_we), 16'd0);
        chk("t6_gap_ready", 16'(op_ready), 16'd1);
        @(posedge clk); #1;
        chk("t6_we2", 16'(mem_we), 16'd1);
        op_data = 12'h033; op_last = 1'b1;
        @(posedge clk); #1;
        chk("t6_gap2_ready", 16'(op_ready), 16'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_valid = 1'b0; op_last = 1'b0;
        chk("t6_we3", 16'(mem_we), 16'd1);
        chk("t6_addr3", 16'(mem_addr), 16'd2);
        @(posedge clk); #1;
        chk("t6_done", 16'(done), 16'd1);
        chk("t6_busy", 16'(busy), 16'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_writes", 16'(exp_addr_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
